piso_gen: RTL
=============

PISO_GEN -- requirements
Module: piso_gen

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, meaning input word width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 2, meaning output beat width in bits.
REQ-003 The block SHALL have parameter LSB_FIRST, default 0, meaning beat order (0 = most-significant beat first, 1 = least-significant beat first).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port din, valid_ready_std_if.in, DATAWIDTH=IN_W: parallel word input.
REQ-007 The block SHALL have port dout, valid_ready_std_if.out, DATAWIDTH=OUT_W: serial beat output.
REQ-008 The block SHALL have port last, output, 1 bit: final beat of the current word, qualified by dout.valid.
REQ-009 The block SHALL have port beat_idx, output, $clog2(IN_W/OUT_W) bits (minimum 1): index of the beat currently on dout.

Function
REQ-010 The block SHALL reject elaboration (fatal assertion) unless IN_W is a multiple of OUT_W and IN_W/OUT_W >= 2.
REQ-011 The block SHALL implement two states: IDLE (no word held) and SHIFT (word held, beat on dout).
REQ-012 A transfer on either interface SHALL occur only on a cycle where both valid and ready are 1.
REQ-013 In IDLE, din.ready SHALL be 1, dout.valid SHALL be 0, and last SHALL be 0.
REQ-014 An IDLE din transfer SHALL capture din.data, go to SHIFT, and present beat 0 with dout.valid=1 on the next cycle (one-cycle latency).
REQ-015 With LSB_FIRST=0, beat k SHALL be data[IN_W-1-k*OUT_W -: OUT_W]; with LSB_FIRST=1, beat k SHALL be data[k*OUT_W +: OUT_W].
REQ-016 In SHIFT, dout.data, dout.valid, last and beat_idx SHALL remain stable while dout.ready=0.
REQ-017 A dout transfer on a non-final beat SHALL advance beat_idx by 1 on the next cycle.
REQ-018 last SHALL be 1 exactly when in SHIFT and beat_idx = IN_W/OUT_W-1.
REQ-019 In SHIFT, din.ready SHALL equal last AND dout.ready (combinational), so the block can accept a new word as the final beat leaves.
REQ-020 A simultaneous final-beat dout transfer and din transfer SHALL load the new word and present its beat 0 on the next cycle, staying in SHIFT with no idle bubble.
REQ-021 A final-beat dout transfer without a din transfer SHALL return the block to IDLE.
REQ-022 din.data SHALL be sampled only on a din transfer; changes to it at any other time SHALL NOT affect dout.
REQ-023 Sustained throughput SHALL be one OUT_W beat per cycle when din.valid=1 and dout.ready=1 continuously.
REQ-024 No output SHALL depend combinationally on din.valid or din.data.

Reset
REQ-025 Assertion of rst_n=0 SHALL, without waiting for a clock edge, force IDLE, dout.valid=0, dout.data=0, last=0, beat_idx=0 and the held word to 0.
REQ-026 Reset asserted in the middle of a word SHALL discard that word; after reset release, no beat of it SHALL ever appear.
REQ-027 din.ready SHALL be 0 while rst_n=0.
REQ-028 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 The state enum (IDLE, SHIFT) SHALL be defined in a shared package piso_gen_pkg.
REQ-030 piso_gen_pkg SHALL provide a beats-per-word function taking (IN_W, OUT_W).
REQ-031 The block SHALL be a single module with no sub-module, built from one held-word register, one beat counter and the state register.

Verification
REQ-032 Defaults, din=8'hCD, dout.ready=1: dout SHALL give 2'b11, 2'b00, 2'b11, 2'b01 on four consecutive cycles, with last=1 only on 2'b01.
REQ-033 LSB_FIRST=1, din=8'hCD: dout SHALL give 2'b01, 2'b11, 2'b00, 2'b11.
REQ-034 din=8'hCD, with dout.ready held 0 for 3 cycles after beat 0: beat 0 (2'b11) SHALL stay stable for those cycles, and din.ready SHALL stay 0.
REQ-035 din.valid=1 continuously with words 8'hCD then 8'h27, dout.ready=1: eight beats SHALL appear back-to-back (11,00,11,01,00,10,01,11) with no gap, and din.ready=1 on the cycle of the first last beat.
REQ-036 rst_n pulsed low while beat_idx=2 of word 8'hAD: outputs SHALL go to 0 immediately, and after release the next word 8'h27 SHALL start at beat 0 with no 8'hAD residue.
REQ-037 IN_W=16, OUT_W=4, din=16'hBEEF: dout SHALL give 4'hB, 4'hE, 4'hE, 4'hF, with last on 4'hF and beat_idx counting 0..3.

Source files
------------

// File: rtl/piso_gen_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out beat generator.
package piso_gen_pkg;

  typedef enum logic {StIdle, StShift} piso_state_e;

  function automatic int unsigned beats_per_word(input int unsigned in_w,
                                                 input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Beat index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/valid_ready_std_if.sv
// Plain valid/ready handshake bundle with sink (in) and source (out) views.
interface valid_ready_std_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic                 valid;
  logic                 ready;
  logic [DATAWIDTH-1:0] data;

  modport in  (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/piso_gen.sv
// Splits each accepted IN_W-bit word into IN_W/OUT_W beats on a valid/ready stream,
// accepting the next word on the cycle the final beat leaves.
module piso_gen
  import piso_gen_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 2,
  parameter bit          LSB_FIRST = 1'b0,
  localparam int unsigned Beats    = beats_per_word(IN_W, OUT_W),
  localparam int unsigned IdxW     = idx_width(Beats)
) (
  input  logic                clk,
  input  logic                rst_n,
  valid_ready_std_if.in       din,
  valid_ready_std_if.out      dout,
  output logic                last,
  output logic [IdxW-1:0]     beat_idx
);

  if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_params
    $fatal(1, "piso_gen: IN_W must be a multiple of OUT_W giving at least two beats");
  end

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Beats - 1);

  piso_state_e     state_q;
  logic [IN_W-1:0] word_q;
  logic [IdxW-1:0] idx_q;

  logic            final_beat;
  logic            din_fire;
  logic            dout_fire;
  logic [IN_W-1:0] word_shifted;

  assign final_beat = (state_q == StShift) && (idx_q == LastIdx);
  assign dout_fire  = (state_q == StShift) && dout.ready;

  // Ready is forced low in reset so no word can slip in while state is being cleared.
  assign din.ready  = rst_n && ((state_q == StIdle) || (final_beat && dout.ready));
  assign din_fire   = din.valid && din.ready;

  // The held word is shifted so the current beat always sits at a fixed end.
  if (LSB_FIRST) begin : g_lsb
    assign word_shifted = word_q >> OUT_W;
    assign dout.data    = word_q[OUT_W-1:0];
  end else begin : g_msb
    assign word_shifted = word_q << OUT_W;
    assign dout.data    = word_q[IN_W-1 -: OUT_W];
  end

  assign dout.valid = (state_q == StShift);
  assign last       = final_beat;
  assign beat_idx   = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (din_fire) begin
            word_q  <= din.data;
            idx_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (dout_fire) begin
            if (final_beat) begin
              idx_q <= '0;
              if (din_fire) begin
                word_q <= din.data;
              end else begin
                word_q  <= '0;
                state_q <= StIdle;
              end
            end else begin
              word_q <= word_shifted;
              idx_q  <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
